// File: rtl/seeg_pkg.sv
// seeg_pkg: shared definitions for the sEEG mode sequencer.
//   - Command word bit indices (control register 0).
//   - Main and stimulation FSM state encodings.
//   - Bit positions inside the 8-bit status word.
package seeg_pkg;

    localparam int unsigned CMD_START_REC      = 0;
    localparam int unsigned CMD_STOP_REC       = 1;
    localparam int unsigned CMD_START_ZCHK     = 2;
    localparam int unsigned CMD_START_STIM_FIN = 6;
    localparam int unsigned CMD_START_STIM_INF = 7;
    localparam int unsigned CMD_STOP_STIM_INF  = 8;
    localparam int unsigned CMD_CLR_ERR        = 31;

    typedef enum logic [1:0] {
        StIdle,
        StZcheck,
        StRecord,
        StDrain
    } main_state_e;

    typedef enum logic [1:0] {
        StimIdle,
        StimFin,
        StimInf
    } stim_state_e;

    localparam int unsigned STAT_RECORD   = 0;
    localparam int unsigned STAT_ZCHECK   = 1;
    localparam int unsigned STAT_STIM     = 2;
    localparam int unsigned STAT_STIM_INF = 3;
    localparam int unsigned STAT_DRAINING = 4;
    localparam int unsigned STAT_CMD_ERR  = 5;

endpackage

// File: rtl/seeg_frame_counter.sv
// seeg_frame_counter: loadable frame counter.
//   clk, rst : clock, synchronous active-high reset
//   load     : latch len as the run length (0 means 1) and clear the count
//   len      : run length sampled on load
//   tick     : count one frame
//   count    : current count (0 .. length-1)
//   wrap     : combinational, high when this tick completes the run; count wraps to 0
module seeg_frame_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] len,
    input  logic             tick,
    output logic [CNT_W-1:0] count,
    output logic             wrap
);

    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] limit_q, limit_d;
    logic             at_last;

    assign at_last = (count_q == limit_q - CNT_W'(1));
    // Completion is reported even if a reload happens in the same cycle.
    assign wrap    = tick && at_last;
    assign count   = count_q;

    always_comb begin
        count_d = count_q;
        limit_d = limit_q;
        if (load) begin
            limit_d = (len == '0) ? CNT_W'(1) : len;
            count_d = '0;
        end else if (tick) begin
            count_d = at_last ? '0 : count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
            limit_q <= '0;
        end else begin
            count_q <= count_d;
            limit_q <= limit_d;
        end
    end

endmodule

// File: rtl/seeg_mode_sequencer.sv
// seeg_mode_sequencer: decodes one-hot command writes and sequences record, impedance
// check and stimulation enables; counts frames to close record batches and time runs.
//   clk, rst       : clock, synchronous active-high reset
//   cmd_wr/cmd_data: command register write strobe and data
//   batch_size, stim_count, zcheck_frames : run lengths, sampled at start
//   frame_tick     : one pulse per acquired frame
//   record_en, zcheck_en, stim_en, stim_infinite : registered enables
//   batch_last, zcheck_done : one-cycle completion pulses
//   cmd_err        : sticky illegal-command flag
//   status         : {2'b0, cmd_err, draining, stim_infinite, stim_en, zcheck_en, record_en}
// Build option: define SEEG_SEQ_ZCHECK_EN to include the impedance-check mode.
module seeg_mode_sequencer #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_wr,
    input  logic [31:0]      cmd_data,
    input  logic [CNT_W-1:0] batch_size,
    input  logic [CNT_W-1:0] stim_count,
    input  logic [CNT_W-1:0] zcheck_frames,
    input  logic             frame_tick,
    output logic             record_en,
    output logic             zcheck_en,
    output logic             stim_en,
    output logic             stim_infinite,
    output logic             batch_last,
    output logic             zcheck_done,
    output logic             cmd_err,
    output logic [7:0]       status
);
    import seeg_pkg::*;

    main_state_e main_q, main_d;
    stim_state_e stim_q, stim_d;

    logic cmd_valid;
    logic c_start_rec, c_stop_rec, c_start_z, c_start_sf, c_start_si, c_stop_si, c_clr;
    logic [3:0] starts;
    logic multi_start;

    assign cmd_valid   = cmd_wr && (cmd_data != '0);
    assign c_start_rec = cmd_valid && cmd_data[CMD_START_REC];
    assign c_stop_rec  = cmd_valid && cmd_data[CMD_STOP_REC];
    assign c_start_z   = cmd_valid && cmd_data[CMD_START_ZCHK];
    assign c_start_sf  = cmd_valid && cmd_data[CMD_START_STIM_FIN];
    assign c_start_si  = cmd_valid && cmd_data[CMD_START_STIM_INF];
    assign c_stop_si   = cmd_valid && cmd_data[CMD_STOP_STIM_INF];
    assign c_clr       = cmd_valid && cmd_data[CMD_CLR_ERR];
    assign starts      = {c_start_rec, c_start_z, c_start_sf, c_start_si};
    assign multi_start = (starts & (starts - 4'd1)) != 4'd0;

    // Counters only see ticks while the registered state is already counting.
    logic batch_tick, batch_load, batch_wrap, batch_zero;
    logic stim_tick, stim_load, stim_wrap;
    logic zchk_tick, zchk_load, zchk_wrap;
    logic [CNT_W-1:0] batch_count;
    logic [CNT_W-1:0] unused_stim_count;

    assign batch_tick = frame_tick && (main_q == StRecord || main_q == StDrain);
    assign stim_tick  = frame_tick && (stim_q == StimFin);
    assign zchk_tick  = frame_tick && (main_q == StZcheck);
    // Batch count after this cycle's tick, used to decide stop -> IDLE vs DRAIN.
    assign batch_zero = batch_wrap || (batch_count == '0 && !batch_tick);

    seeg_frame_counter #(.CNT_W(CNT_W)) u_batch_cnt (
        .clk   (clk),
        .rst   (rst),
        .load  (batch_load),
        .len   (batch_size),
        .tick  (batch_tick),
        .count (batch_count),
        .wrap  (batch_wrap)
    );

    seeg_frame_counter #(.CNT_W(CNT_W)) u_stim_cnt (
        .clk   (clk),
        .rst   (rst),
        .load  (stim_load),
        .len   (stim_count),
        .tick  (stim_tick),
        .count (unused_stim_count),
        .wrap  (stim_wrap)
    );

`ifdef SEEG_SEQ_ZCHECK_EN
    logic [CNT_W-1:0] unused_zchk_count;

    seeg_frame_counter #(.CNT_W(CNT_W)) u_zchk_cnt (
        .clk   (clk),
        .rst   (rst),
        .load  (zchk_load),
        .len   (zcheck_frames),
        .tick  (zchk_tick),
        .count (unused_zchk_count),
        .wrap  (zchk_wrap)
    );
`else
    logic unused_zchk;
    assign zchk_wrap   = 1'b0;
    assign unused_zchk = ^{zcheck_frames, zchk_load, zchk_tick};
`endif

    logic err_set;

    // Next state: frame-driven completions, then stops, then starts.
    always_comb begin
        main_d     = main_q;
        stim_d     = stim_q;
        err_set    = 1'b0;
        batch_load = 1'b0;
        stim_load  = 1'b0;
        zchk_load  = 1'b0;

        if (main_q == StDrain && batch_wrap) main_d = StIdle;
        if (main_q == StZcheck && zchk_wrap) main_d = StIdle;
        if (stim_q == StimFin && stim_wrap)  stim_d = StimIdle;

        if (c_stop_rec) begin
            stim_d = StimIdle;
            case (main_d)
                StRecord: main_d = batch_zero ? StIdle : StDrain;
                StZcheck: main_d = StIdle;
                default:  ;
            endcase
        end
        if (c_stop_si) stim_d = StimIdle;

        if (multi_start) begin
            err_set = 1'b1;
        end else begin
            if (c_start_rec) begin
                case (main_d)
                    StIdle: begin
                        main_d     = StRecord;
                        batch_load = 1'b1;
                    end
                    StRecord: ;
                    default: err_set = 1'b1;
                endcase
            end
            if (c_start_z) begin
`ifdef SEEG_SEQ_ZCHECK_EN
                if (main_d == StIdle) begin
                    main_d    = StZcheck;
                    zchk_load = 1'b1;
                end else begin
                    err_set = 1'b1;
                end
`else
                err_set = 1'b1;
`endif
            end
            if (c_start_sf || c_start_si) begin
                if ((main_d == StIdle || main_d == StRecord) && stim_d == StimIdle) begin
                    stim_d    = c_start_sf ? StimFin : StimInf;
                    stim_load = c_start_sf;
                end else begin
                    err_set = 1'b1;
                end
            end
        end
    end

    // Output next values, registered alongside the state.
    logic record_en_d, zcheck_en_d, stim_en_d, stim_inf_d, draining_d, err_d;
    logic draining_q;

    always_comb begin
        record_en_d = (main_d == StRecord) || (main_d == StDrain);
`ifdef SEEG_SEQ_ZCHECK_EN
        zcheck_en_d = (main_d == StZcheck);
`else
        zcheck_en_d = 1'b0;
`endif
        stim_en_d   = (stim_d != StimIdle);
        stim_inf_d  = (stim_d == StimInf);
        draining_d  = (main_d == StDrain);
        // Setting wins over clearing within one write.
        err_d       = err_set || (cmd_err && !c_clr);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            main_q        <= StIdle;
            stim_q        <= StimIdle;
            record_en     <= 1'b0;
            zcheck_en     <= 1'b0;
            stim_en       <= 1'b0;
            stim_infinite <= 1'b0;
            draining_q    <= 1'b0;
            batch_last    <= 1'b0;
            zcheck_done   <= 1'b0;
            cmd_err       <= 1'b0;
        end else begin
            main_q        <= main_d;
            stim_q        <= stim_d;
            record_en     <= record_en_d;
            zcheck_en     <= zcheck_en_d;
            stim_en       <= stim_en_d;
            stim_infinite <= stim_inf_d;
            draining_q    <= draining_d;
            batch_last    <= batch_wrap;
            zcheck_done   <= zchk_wrap;
            cmd_err       <= err_d;
        end
    end

    always_comb begin
        status                = '0;
        status[STAT_RECORD]   = record_en;
        status[STAT_ZCHECK]   = zcheck_en;
        status[STAT_STIM]     = stim_en;
        status[STAT_STIM_INF] = stim_infinite;
        status[STAT_DRAINING] = draining_q;
        status[STAT_CMD_ERR]  = cmd_err;
    end

endmodule

// File: tb/tb_seeg_mode_sequencer.sv
// Bench for seeg_mode_sequencer: a per-cycle vector table for the main scenarios plus
// short hand-written sequences for length sampling, zero length and mid-run reset.
module tb_seeg_mode_sequencer;

    localparam int unsigned CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             cmd_wr;
    logic [31:0]      cmd_data;
    logic [CNT_W-1:0] batch_size;
    logic [CNT_W-1:0] stim_count;
    logic [CNT_W-1:0] zcheck_frames;
    logic             frame_tick;
    logic             record_en, zcheck_en, stim_en, stim_infinite;
    logic             batch_last, zcheck_done, cmd_err;
    logic [7:0]       status;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seeg_mode_sequencer #(.CNT_W(CNT_W)) dut (
        .clk           (clk),
        .rst           (rst),
        .cmd_wr        (cmd_wr),
        .cmd_data      (cmd_data),
        .batch_size    (batch_size),
        .stim_count    (stim_count),
        .zcheck_frames (zcheck_frames),
        .frame_tick    (frame_tick),
        .record_en     (record_en),
        .zcheck_en     (zcheck_en),
        .stim_en       (stim_en),
        .stim_infinite (stim_infinite),
        .batch_last    (batch_last),
        .zcheck_done   (zcheck_done),
        .cmd_err       (cmd_err),
        .status        (status)
    );

    typedef struct {
        logic        wr;
        logic [31:0] data;
        logic        tick;
        logic [7:0]  st;
        logic        bl;
        logic        zd;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic wr, input logic [31:0] data, input logic tick,
                       input logic [7:0] st, input logic bl, input logic zd);
        vec_t v;
        v.wr = wr; v.data = data; v.tick = tick; v.st = st; v.bl = bl; v.zd = zd;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // One cycle: drive inputs, clock, sample 1 time unit after the edge.
    task automatic step(input logic wr, input logic [31:0] data, input logic tick);
        cmd_wr = wr; cmd_data = data; frame_tick = tick;
        @(posedge clk);
        #1;
        cmd_wr = 1'b0; cmd_data = '0; frame_tick = 1'b0;
    endtask

    // Compares status plus the individual output ports against one expectation.
    task automatic chk_all(input string name, input logic [7:0] st, input logic bl,
                           input logic zd);
        logic [6:0] exp_ports;
        exp_ports = {st[5], st[3], st[2], st[1], st[0], bl, zd};
        chk({name, "_status"}, {24'd0, status}, {24'd0, st});
        chk({name, "_ports"},
            {25'd0, cmd_err, stim_infinite, stim_en, zcheck_en, record_en, batch_last,
             zcheck_done},
            {25'd0, exp_ports});
    endtask

    initial begin
        rst = 1'b1; cmd_wr = 1'b0; cmd_data = '0; frame_tick = 1'b0;
        batch_size = 16'd4; stim_count = 16'd5; zcheck_frames = 16'd3;

        // Record: batch of 4, 10 ticks, stop with count 2 -> drain until tick 12.
        add(1, 32'h1, 0, 8'h01, 0, 0);
        for (int i = 1; i <= 10; i++) add(0, 0, 1, 8'h01, (i % 4) == 0, 0);
        add(1, 32'h2, 0, 8'h11, 0, 0);
        add(0, 0, 1, 8'h11, 0, 0);
        add(0, 0, 1, 8'h00, 1, 0);
        add(0, 0, 0, 8'h00, 0, 0);
        // Record + finite stim of 5 frames, then infinite stim, 7 ticks, stop.
        add(1, 32'h1, 0, 8'h01, 0, 0);
        add(1, 32'h40, 0, 8'h05, 0, 0);
        add(0, 0, 1, 8'h05, 0, 0);
        add(0, 0, 1, 8'h05, 0, 0);
        add(0, 0, 1, 8'h05, 0, 0);
        add(0, 0, 1, 8'h05, 1, 0);
        add(0, 0, 1, 8'h01, 0, 0);
        add(1, 32'h80, 0, 8'h0D, 0, 0);
        add(0, 0, 1, 8'h0D, 0, 0);
        add(0, 0, 1, 8'h0D, 0, 0);
        add(0, 0, 1, 8'h0D, 1, 0);
        add(0, 0, 1, 8'h0D, 0, 0);
        add(0, 0, 1, 8'h0D, 0, 0);
        add(0, 0, 1, 8'h0D, 0, 0);
        add(0, 0, 1, 8'h0D, 1, 0);
        add(1, 32'h100, 0, 8'h01, 0, 0);
        // Record + infinite stim, stop_record at count 0 clears everything.
        add(1, 32'h80, 0, 8'h0D, 0, 0);
        add(1, 32'h2, 0, 8'h00, 0, 0);
        // Two starts rejected; zero write ignored; clear_err.
        add(1, 32'hC0, 0, 8'h20, 0, 0);
        add(1, 32'h0, 0, 8'h20, 0, 0);
        add(1, 32'h8000_0000, 0, 8'h00, 0, 0);
`ifdef SEEG_SEQ_ZCHECK_EN
        add(1, 32'h4, 0, 8'h02, 0, 0);
        add(0, 0, 1, 8'h02, 0, 0);
        add(1, 32'h40, 0, 8'h22, 0, 0);
        add(0, 0, 1, 8'h22, 0, 0);
        add(0, 0, 1, 8'h20, 0, 1);
        add(1, 32'h8000_0000, 0, 8'h00, 0, 0);
`else
        add(1, 32'h4, 0, 8'h20, 0, 0);
        add(0, 0, 1, 8'h20, 0, 0);
        add(1, 32'h8000_0000, 0, 8'h00, 0, 0);
`endif
        // Tick in the start cycle is not counted; tick with stop is counted first.
        add(1, 32'h1, 1, 8'h01, 0, 0);
        add(0, 0, 1, 8'h01, 0, 0);
        add(0, 0, 1, 8'h01, 0, 0);
        add(0, 0, 1, 8'h01, 0, 0);
        add(1, 32'h2, 1, 8'h00, 1, 0);
        // Start in DRAIN is an error; stop_stim while idle is harmless.
        add(1, 32'h1, 0, 8'h01, 0, 0);
        add(0, 0, 1, 8'h01, 0, 0);
        add(1, 32'h2, 0, 8'h11, 0, 0);
        add(1, 32'h40, 0, 8'h31, 0, 0);
        add(1, 32'h100, 1, 8'h31, 0, 0);
        add(0, 0, 1, 8'h31, 0, 0);
        add(0, 0, 1, 8'h20, 1, 0);
        add(1, 32'h8000_0000, 0, 8'h00, 0, 0);

        repeat (2) @(posedge clk);
        #1;
        chk_all("reset", 8'h00, 0, 0);
        rst = 1'b0;

        foreach (vecs[i]) begin
            step(vecs[i].wr, vecs[i].data, vecs[i].tick);
            chk_all($sformatf("vec%0d", i), vecs[i].st, vecs[i].bl, vecs[i].zd);
        end

        // Length is sampled at start only.
        batch_size = 16'd2;
        step(1, 32'h1, 0);
        batch_size = 16'd8;
        step(0, 0, 1);
        chk_all("len_hold_t1", 8'h01, 0, 0);
        step(0, 0, 1);
        chk_all("len_hold_t2", 8'h01, 1, 0);
        step(1, 32'h2, 0);
        chk_all("len_hold_stop", 8'h00, 0, 0);

        // Zero batch size behaves as 1: every tick closes a batch.
        batch_size = 16'd0;
        step(1, 32'h1, 0);
        step(0, 0, 1);
        chk_all("zero_len_t1", 8'h01, 1, 0);
        step(0, 0, 1);
        chk_all("zero_len_t2", 8'h01, 1, 0);

        // Reset on a completing tick: no batch_last, all outputs back to 0.
        rst = 1'b1;
        step(1, 32'h40, 1);
        chk_all("rst_mid_run", 8'h00, 0, 0);
        rst = 1'b0;
        step(0, 0, 1);
        chk_all("after_rst", 8'h00, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
